// File: rtl/pes_elc_pkg.sv
// pes_elc_pkg: shared types and constants for the SCAN elevator controller.
//   state_e  : controller state (IDLE / MOVE / DOOR)
//   DIR_UP / DIR_DOWN : encoding of the direction output
//   max_int  : helper for sizing the shared travel/door timer
package pes_elc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pes_elc_scan_dir.sv
// pes_elc_scan_dir: combinational SCAN look-ahead over the pending bitmap.
//   pending       in  NUM_FLOORS  latched request bitmap
//   current_floor in  FLOOR_W     floor the car is at
//   direction     in  1           1 = up, 0 = down
//   any_ahead     out 1           a request lies beyond the car in `direction`
//   any_behind    out 1           a request lies behind the car
//   here          out 1           a request exists at current_floor
module pes_elc_scan_dir
  import pes_elc_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  direction,
  output logic                  any_ahead,
  output logic                  any_behind,
  output logic                  here
);

  logic any_above;
  logic any_below;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop can leave a value held and infer a latch.
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    here      = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (FLOOR_W'(i) > current_floor)      any_above = 1'b1;
        else if (FLOOR_W'(i) < current_floor) any_below = 1'b1;
        else                                  here      = 1'b1;
      end
    end
  end

  assign any_ahead  = (direction == DIR_UP) ? any_above : any_below;
  assign any_behind = (direction == DIR_UP) ? any_below : any_above;

endmodule

// File: rtl/pes_elc_scan.sv
// pes_elc_scan: single-car elevator controller, latched multi-request set,
// SCAN scheduling, per-floor travel timer and door dwell timer with
// obstruction / overweight holds.
//   clk, reset (async, active-low)
//   call_valid/call_floor     : call strobe and binary floor number
//   over_time/over_weight     : door holds, honoured only while the door is open
//   current_floor, direction, moving, door_open : car status
//   complete                  : one-cycle pulse after a floor is served
//   door_alert, weight_alert  : hold indicators (DOOR state only)
//   pending                   : latched request bitmap
// Optional feature: define PES_ELC_FIRE_RECALL_EN to add input fire_recall,
// which clears requests, sends the car to floor 0 and holds its door open.
module pes_elc_scan
  import pes_elc_pkg::*;
#(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = $clog2(NUM_FLOORS),
  parameter int FLOOR_CYCLES = 4,
  parameter int DOOR_CYCLES  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic                  over_time,
  input  logic                  over_weight,
`ifdef PES_ELC_FIRE_RECALL_EN
  input  logic                  fire_recall,
`endif
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  complete,
  output logic                  door_alert,
  output logic                  weight_alert,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TMR_W = $clog2(max_int(FLOOR_CYCLES, DOOR_CYCLES)) + 1;
  localparam logic [TMR_W-1:0] FLOOR_RELOAD = TMR_W'(FLOOR_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOOR_RELOAD  = TMR_W'(DOOR_CYCLES - 1);

  state_e                  state_q,        state_d;
  logic [FLOOR_W-1:0]      floor_q,        floor_d;
  logic                    dir_q,          dir_d;
  logic [TMR_W-1:0]        timer_q,        timer_d;
  logic [NUM_FLOORS-1:0]   pending_q,      pending_d;
  logic                    complete_q,     complete_d;
  logic                    door_alert_q,   door_alert_d;
  logic                    weight_alert_q, weight_alert_d;

  logic                    fire;
`ifdef PES_ELC_FIRE_RECALL_EN
  assign fire = fire_recall;
`else
  assign fire = 1'b0;
`endif

  logic any_ahead, any_behind, here;

  pes_elc_scan_dir #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_dir (
    .pending       (pending_q),
    .current_floor (floor_q),
    .direction     (dir_q),
    .any_ahead     (any_ahead),
    .any_behind    (any_behind),
    .here          (here)
  );

  // One-hot decodes: out-of-range call floors match no bit and are dropped.
  logic [NUM_FLOORS-1:0] call_mask, floor_mask, step_mask;
  logic [FLOOR_W-1:0]    step_floor;
  logic                  door_call, at_ground, can_step;

  always_comb begin
    at_ground  = (floor_q == '0);
    can_step   = (dir_q == DIR_UP) ? (floor_q != FLOOR_W'(NUM_FLOORS - 1)) : !at_ground;
    step_floor = !can_step        ? floor_q :
                 (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    door_call  = (state_q == ST_DOOR) && call_valid && (call_floor == floor_q);
    call_mask  = '0;
    floor_mask = '0;
    step_mask  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      call_mask[i]  = call_valid && !fire && (call_floor == FLOOR_W'(i));
      floor_mask[i] = (floor_q == FLOOR_W'(i));
      step_mask[i]  = (step_floor == FLOOR_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    timer_d    = timer_q;
    complete_d = 1'b0;
    // A call for the floor whose door is open just holds the door instead.
    pending_d  = pending_q | (door_call ? (call_mask & ~floor_mask) : call_mask);

    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          if (at_ground) begin
            state_d = ST_DOOR;
            timer_d = DOOR_RELOAD;
          end else begin
            state_d = ST_MOVE;
            dir_d   = DIR_DOWN;
            timer_d = FLOOR_RELOAD;
          end
        end else if (here) begin
          state_d    = ST_DOOR;
          timer_d    = DOOR_RELOAD;
          pending_d  = pending_d & ~floor_mask;
          complete_d = 1'b1;
        end else if (|pending_q) begin
          state_d = ST_MOVE;
          timer_d = FLOOR_RELOAD;
          if (!any_ahead && any_behind) dir_d = ~dir_q;
        end
      end

      ST_MOVE: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          timer_d = FLOOR_RELOAD;
          floor_d = step_floor;
          if (fire) begin
            // Recall: the step just taken completes, then the car heads down.
            dir_d = DIR_DOWN;
            if (step_floor == '0) begin
              state_d = ST_DOOR;
              timer_d = DOOR_RELOAD;
            end
          end else if (|(pending_q & step_mask)) begin
            state_d    = ST_DOOR;
            timer_d    = DOOR_RELOAD;
            pending_d  = pending_d & ~step_mask;
            complete_d = 1'b1;
          end else if (pending_q == '0 || !can_step) begin
            // Nothing left to chase: let IDLE re-decide from a standstill.
            state_d = ST_IDLE;
          end
        end
      end

      ST_DOOR: begin
        if (over_time || over_weight || door_call || (fire && at_ground)) begin
          timer_d = DOOR_RELOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (fire) pending_d = '0;

    door_alert_d   = (state_d == ST_DOOR) && (over_time || fire);
    weight_alert_d = (state_d == ST_DOOR) && over_weight;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      floor_q        <= '0;
      dir_q          <= DIR_UP;
      timer_q        <= '0;
      pending_q      <= '0;
      complete_q     <= 1'b0;
      door_alert_q   <= 1'b0;
      weight_alert_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      floor_q        <= floor_d;
      dir_q          <= dir_d;
      timer_q        <= timer_d;
      pending_q      <= pending_d;
      complete_q     <= complete_d;
      door_alert_q   <= door_alert_d;
      weight_alert_q <= weight_alert_d;
    end
  end

  assign current_floor = floor_q;
  assign direction     = dir_q;
  assign moving        = (state_q == ST_MOVE);
  assign door_open     = (state_q == ST_DOOR);
  assign complete      = complete_q;
  assign door_alert    = door_alert_q;
  assign weight_alert  = weight_alert_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_pes_elc_scan.sv
// tb_pes_elc_scan: directed self-checking bench for pes_elc_scan
// (NUM_FLOORS=8, FLOOR_W=4 so out-of-range floor 9 is expressible,
// FLOOR_CYCLES=4, DOOR_CYCLES=6). Inputs change 1 time unit after a rising
// edge; outputs are sampled there too.
module tb_pes_elc_scan;

  localparam int NF = 8;
  localparam int FW = 4;

  logic          clk;
  logic          reset;
  logic          call_valid;
  logic [FW-1:0] call_floor;
  logic          over_time;
  logic          over_weight;
  logic [FW-1:0] current_floor;
  logic          direction;
  logic          moving;
  logic          door_open;
  logic          complete;
  logic          door_alert;
  logic          weight_alert;
  logic [NF-1:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  pes_elc_scan #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .FLOOR_CYCLES (4),
    .DOOR_CYCLES  (6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .call_valid    (call_valid),
    .call_floor    (call_floor),
    .over_time     (over_time),
    .over_weight   (over_weight),
    .current_floor (current_floor),
    .direction     (direction),
    .moving        (moving),
    .door_open     (door_open),
    .complete      (complete),
    .door_alert    (door_alert),
    .weight_alert  (weight_alert),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 door opens, 1 door closes, 2 fully idle with nothing pending, 3 moving
  task automatic wait_until(input string tag, input int kind);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick(1);
      case (kind)
        0:       ok = door_open;
        1:       ok = !door_open;
        2:       ok = !moving && !door_open && (pending == '0);
        default: ok = moving;
      endcase
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic place_call(input logic [FW-1:0] f);
    call_valid = 1'b1;
    call_floor = f;
    tick(1);
    call_valid = 1'b0;
  endtask

  initial begin
    int exp_floor;
    int n_complete;

    reset       = 1'b0;
    call_valid  = 1'b1;
    call_floor  = 4'd3;
    over_time   = 1'b0;
    over_weight = 1'b1;

    // Reset held with a call and a hold active.
    tick(3);
    check("rst_pending",  pending,       8'h00);
    check("rst_floor",    current_floor, 4'd0);
    check("rst_dir",      direction,     1'b1);
    check("rst_moving",   moving,        1'b0);
    check("rst_door",     door_open,     1'b0);
    check("rst_complete", complete,      1'b0);
    check("rst_walert",   weight_alert,  1'b0);
    check("rst_dalert",   door_alert,    1'b0);
    call_valid  = 1'b0;
    over_weight = 1'b0;
    reset       = 1'b1;
    tick(2);
    check("post_rst_idle", moving, 1'b0);

    // Call 3 from floor 0: steps at t+5/t+9/t+13, door t+13..t+18, idle t+19.
    place_call(4'd3);
    check("c3_latched", pending, 8'h08);
    check("c3_not_yet_moving", moving, 1'b0);
    n_complete = 0;
    for (int k = 1; k <= 19; k++) begin
      tick(1);
      exp_floor = (k < 5) ? 0 : (k < 9) ? 1 : (k < 13) ? 2 : 3;
      check($sformatf("c3_floor_k%0d", k), current_floor, exp_floor);
      check($sformatf("c3_moving_k%0d", k), moving, (k >= 1 && k <= 12));
      check($sformatf("c3_door_k%0d", k), door_open, (k >= 13 && k <= 18));
      if (complete) n_complete++;
      if (k == 13) check("c3_pending_cleared", pending, 8'h00);
      if (k == 13) check("c3_complete_after_arrival", complete, 1'b1);
    end
    check("c3_one_complete", n_complete, 1);

    // Move to floor 4, then SCAN: pending {6,2} while heading up.
    place_call(4'd4);
    wait_until("to4_idle", 2);
    check("to4_floor", current_floor, 4'd4);
    check("to4_dir", direction, 1'b1);
    place_call(4'd6);
    place_call(4'd2);
    check("scan_pending", pending, 8'h44);
    check("scan_moving_up", moving, 1'b1);
    check("scan_dir_up", direction, 1'b1);
    wait_until("scan_open6", 0);
    check("scan_floor6", current_floor, 4'd6);
    check("scan_dir6", direction, 1'b1);
    check("scan_complete6", complete, 1'b1);
    check("scan_pending_after6", pending, 8'h04);
    wait_until("scan_close6", 1);
    wait_until("scan_reverse", 3);
    check("scan_dir_down", direction, 1'b0);
    wait_until("scan_open2", 0);
    check("scan_floor2", current_floor, 4'd2);
    check("scan_dir2", direction, 1'b0);
    check("scan_complete2", complete, 1'b1);
    check("scan_pending_empty", pending, 8'h00);

    // Overweight for 10 cycles starting in the first door cycle at floor 2.
    over_weight = 1'b1;
    tick(1);
    check("ow_alert_on", weight_alert, 1'b1);
    check("ow_no_door_alert", door_alert, 1'b0);
    tick(9);
    check("ow_door_held", door_open, 1'b1);
    check("ow_floor_held", current_floor, 4'd2);
    over_weight = 1'b0;
    tick(1);
    check("ow_alert_off", weight_alert, 1'b0);
    check("ow_door_open_r1", door_open, 1'b1);
    tick(4);
    check("ow_door_open_r5", door_open, 1'b1);
    tick(1);
    check("ow_door_closed_r6", door_open, 1'b0);
    check("ow_floor_end", current_floor, 4'd2);

    // Out-of-range call is ignored.
    place_call(4'd9);
    check("oor_pending", pending, 8'h00);
    tick(2);
    check("oor_no_move", moving, 1'b0);
    check("oor_no_door", door_open, 1'b0);

    // Return to floor 0, then call 0 while idle there.
    place_call(4'd0);
    wait_until("to0_idle", 2);
    check("to0_floor", current_floor, 4'd0);
    place_call(4'd0);
    check("here_latched", pending, 8'h01);
    check("here_door_not_yet", door_open, 1'b0);
    tick(1);
    check("here_door", door_open, 1'b1);
    check("here_complete", complete, 1'b1);
    check("here_pending_clear", pending, 8'h00);
    check("here_no_move", moving, 1'b0);
    over_time = 1'b1;
    tick(1);
    check("here_complete_once", complete, 1'b0);
    check("ot_alert_on", door_alert, 1'b1);
    over_time = 1'b0;
    tick(1);
    check("ot_alert_off", door_alert, 1'b0);
    check("ot_door_still_open", door_open, 1'b1);
    wait_until("here_idle", 2);
    check("here_floor", current_floor, 4'd0);

    // Reset between floors 2 and 3 while travelling to 5.
    place_call(4'd5);
    tick(11);
    check("mid_floor2", current_floor, 4'd2);
    check("mid_moving", moving, 1'b1);
    check("mid_pending", pending, 8'h20);
    reset = 1'b0;
    #1;
    check("async_floor", current_floor, 4'd0);
    check("async_moving", moving, 1'b0);
    check("async_pending", pending, 8'h00);
    check("async_dir", direction, 1'b1);
    tick(1);
    reset = 1'b1;
    tick(3);
    check("after_rst_idle", moving, 1'b0);
    check("after_rst_floor", current_floor, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
